// File: rtl/cordic_div_seq.sv
// Two-entry-capable synchronous FIFO of opaque W-bit words with occupancy tracking.
// Latency: a word pushed on one edge is visible at rd_dat from the next cycle.
// Backpressure: wr_rdy drops when full; rd_vld holds the head until rd_rdy pops it.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign wr_rdy = (cnt != CNT_FULL);
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Sequencer in front of the CORDIC y/x divider: screens operands, runs the divider, signs/saturates.
// Latency: bypass result valid 2 cycles after accept; divided result 1 cycle after div_rdy.
// Backpressure: one op in flight; s_ready only in IDLE with FIFO not full; m_ready low stalls intake.
module cordic_div_seq #(
    parameter int DWIDTH    = 16,
    parameter int ACCURANCY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DWIDTH-1:0]    s_x,
    input  logic [DWIDTH-1:0]    s_y,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ACCURANCY-1:0] m_res,
    output logic                 m_sat,
    output logic [DWIDTH-1:0]    div_x,
    output logic [DWIDTH-1:0]    div_y,
    output logic                 div_req,
    input  logic [ACCURANCY-1:0] div_res,
    input  logic                 div_rdy
);
    localparam logic [DWIDTH-1:0]    OPD_MIN    = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0]    OPD_MIN_P1 = {1'b1, {(DWIDTH-2){1'b0}}, 1'b1};
    localparam logic [ACCURANCY-1:0] RES_MAX    = {1'b0, {(ACCURANCY-1){1'b1}}};
    localparam logic [ACCURANCY-1:0] RES_MIN    = {1'b1, {(ACCURANCY-2){1'b0}}, 1'b1};

    typedef struct packed {
        logic [ACCURANCY-1:0] res;
        logic                 sat;
    } q_ent_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAT  = 2'd1,
        ST_REQ  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 accept;
    logic                 fifo_wr_rdy;
    logic                 push_vld;
    q_ent_t               push_dat;
    q_ent_t               head;
    q_ent_t               byp_ent;
    q_ent_t               norm_ent;

    logic [DWIDTH-1:0]    cx;
    logic [DWIDTH-1:0]    cy;
    logic [DWIDTH-1:0]    ax_in;
    logic [DWIDTH-1:0]    ay_in;
    logic                 bypass_in;
    logic [DWIDTH-1:0]    ax_q;
    logic [DWIDTH-1:0]    ay_q;
    logic                 sgn_q;
    logic                 mag_over;
    logic [ACCURANCY-1:0] mag;

    assign s_ready = !rst && (state == ST_IDLE) && fifo_wr_rdy;
    assign accept  = s_valid && s_ready;

    // Folding the most negative operand keeps |x| and |y| representable in DWIDTH-1 bits.
    assign cx        = (s_x == OPD_MIN) ? OPD_MIN_P1 : s_x;
    assign cy        = (s_y == OPD_MIN) ? OPD_MIN_P1 : s_y;
    assign ax_in     = cx[DWIDTH-1] ? -cx : cx;
    assign ay_in     = cy[DWIDTH-1] ? -cy : cy;
    assign bypass_in = (ax_in == '0) || (ay_in >= ax_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_vld  = 1'b0;
        push_dat  = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = bypass_in ? ST_SAT : ST_REQ;
                end
            end
            ST_SAT: begin
                push_vld  = 1'b1;
                push_dat  = byp_ent;
                state_nxt = ST_IDLE;
            end
            ST_REQ: begin
                if (div_rdy) begin
                    push_vld  = 1'b1;
                    push_dat  = norm_ent;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // div_req follows the next state so it drops on the same edge that captures div_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_x   <= '0;
            div_y   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            sgn_q   <= 1'b0;
            div_req <= 1'b0;
        end else begin
            div_req <= (state_nxt == ST_REQ);
            if (accept) begin
                div_x <= cx;
                div_y <= cy;
                ax_q  <= ax_in;
                ay_q  <= ay_in;
                sgn_q <= s_x[DWIDTH-1] ^ s_y[DWIDTH-1];
            end
        end
    end

    always_comb begin
        byp_ent.res = '0;
        byp_ent.sat = (ax_q == '0);
        if (ay_q != '0) begin
            byp_ent.res = sgn_q ? RES_MIN : RES_MAX;
            byp_ent.sat = 1'b1;
        end
    end

    // Negating zero yields zero, so a zero magnitude never turns into a signed result.
    assign mag_over     = div_res[ACCURANCY-1];
    assign mag          = mag_over ? RES_MAX : div_res;
    assign norm_ent.res = sgn_q ? -mag : mag;
    assign norm_ent.sat = mag_over;

    sync_fifo #(
        .W     ($bits(q_ent_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (push_dat),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (head)
    );

    assign m_res = head.res;
    assign m_sat = head.sat;
endmodule

// File: tb/tb_cordic_div_seq.sv
// Directed bench for cordic_div_seq with a divider stub and a result scoreboard.
module tb_cordic_div_seq;
    localparam int DW = 16;
    localparam int AC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_x = '0;
    logic [DW-1:0] s_y = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [AC-1:0] m_res;
    logic          m_sat;
    logic [DW-1:0] div_x;
    logic [DW-1:0] div_y;
    logic          div_req;
    logic [AC-1:0] div_res;
    logic          div_rdy;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc_n = 0;
    logic [8:0]    sb[$];

    int            stub_lat = AC + 2;
    logic [AC-1:0] stub_res = '0;
    int            stub_cnt = 0;
    logic          stub_fire = 1'b0;
    logic          force_rdy = 1'b0;

    cordic_div_seq #(.DWIDTH(DW), .ACCURANCY(AC)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_x     (s_x),
        .s_y     (s_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_res   (m_res),
        .m_sat   (m_sat),
        .div_x   (div_x),
        .div_y   (div_y),
        .div_req (div_req),
        .div_res (div_res),
        .div_rdy (div_rdy)
    );

    always #5 clk = ~clk;

    // Divider stub: strobes rdy in the stub_lat-th cycle that req is high.
    always @(negedge clk) begin
        if (rst || !div_req) begin
            stub_cnt  <= 0;
            stub_fire <= 1'b0;
        end else begin
            stub_cnt  <= stub_cnt + 1;
            stub_fire <= ((stub_cnt + 1) == stub_lat);
        end
    end
    assign div_rdy = stub_fire | force_rdy;
    assign div_res = stub_res;

    function automatic logic [8:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input logic [AC-1:0] m);
        int xi, yi, ax, ay, r;
        logic sat, sgn;
        logic [31:0] rv;
        xi  = int'($signed(x));
        yi  = int'($signed(y));
        if (xi == -32768) xi = -32767;
        if (yi == -32768) yi = -32767;
        ax  = (xi < 0) ? -xi : xi;
        ay  = (yi < 0) ? -yi : yi;
        sgn = x[DW-1] ^ y[DW-1];
        if (ax == 0 || ay >= ax) begin
            sat = 1'b1;
            if (ay == 0) r = 0;
            else         r = sgn ? -127 : 127;
        end else begin
            r   = int'(m);
            sat = 1'b0;
            if (r > 127) begin
                r   = 127;
                sat = 1'b1;
            end
            if (sgn) r = -r;
        end
        rv = r;
        return {rv[7:0], sat};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        if (rst) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk("sb_extra_output", 32'(sb.size()), 32'd1);
                else                chk("sb_result", {m_res, m_sat}, sb.pop_front());
            end
            if (s_valid && s_ready) sb.push_back(model(s_x, s_y, stub_res));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [AC-1:0] r, output int acc_cyc);
        s_x     = x;
        s_y     = y;
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !s_ready; i++) cyc();
        chk("send_ready", s_ready, 1);
        stub_res = r;
        acc_cyc  = cyc_n;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic wait_mv(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (m_valid) break;
            cyc();
        end
        chk(tag, m_valid, 1);
    endtask

    task automatic bypass_case(input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input logic [8:0] exp);
        int t0;
        send(x, y, 8'h00, t0);
        chk("byp_c1_req", div_req, 0);
        chk("byp_c1_s_ready", s_ready, 0);
        cyc();
        chk("byp_c2_lat", cyc_n - t0, 2);
        chk("byp_c2_m_valid", m_valid, 1);
        chk("byp_c2_req", div_req, 0);
        chk("byp_c2_res", {m_res, m_sat}, exp);
        cyc();
    endtask

    initial begin
        int t0, t1, req_hi;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
        end
        rst = 1'b0;
        cyc();
        chk("idle_s_ready", s_ready, 1);
        chk("idle_m_valid", m_valid, 0);
        chk("idle_div_req", div_req, 0);
        chk("idle_m_res", {m_res, m_sat}, 0);
        chk("idle_div_xy", {div_x, div_y}, 0);

        // Normal divide: negative quotient, latency to m_valid and GAP cycle
        send(16'h4000, 16'hE000, 8'h30, t0);
        chk("norm_req_rise", div_req, 1);
        chk("norm_div_x", div_x, 16'h4000);
        chk("norm_div_y", div_y, 16'hE000);
        chk("norm_s_ready_busy", s_ready, 0);
        req_hi = 1;
        for (int i = 0; i < 40; i++) begin
            if (m_valid) break;
            cyc();
            if (div_req) req_hi++;
        end
        chk("norm_lat", cyc_n - t0, AC + 3);
        chk("norm_req_cycles", req_hi, stub_lat);
        chk("norm_gap_req", div_req, 0);
        chk("norm_gap_s_ready", s_ready, 0);
        chk("norm_res", {m_res, m_sat}, {8'hD0, 1'b0});
        cyc();
        chk("norm_next_s_ready", s_ready, 1);
        chk("norm_popped", m_valid, 0);

        // Bypass cases
        bypass_case(16'h0000, 16'h0005, {8'h7F, 1'b1});
        bypass_case(16'hFFFD, 16'h0003, {8'h81, 1'b1});
        bypass_case(16'h0000, 16'h0000, {8'h00, 1'b1});

        // Operand clamp and magnitude saturation
        send(16'h8000, 16'h4000, 8'hC0, t0);
        chk("clamp_div_x", div_x, 16'h8001);
        chk("clamp_div_y", div_y, 16'h4000);
        wait_mv("clamp_m_valid");
        chk("clamp_res", {m_res, m_sat}, {8'h81, 1'b1});
        cyc();

        // Backpressure: two results held, third waits for a pop
        m_ready = 1'b0;
        send(16'h0000, 16'h0005, 8'h00, t0);
        send(16'h0005, 16'hFFF9, 8'h00, t0);
        cyc();
        cyc();
        chk("bp_full_s_ready", s_ready, 0);
        chk("bp_full_m_valid", m_valid, 1);
        chk("bp_head_first", {m_res, m_sat}, {8'h7F, 1'b1});
        cyc();
        chk("bp_head_stable", {m_res, m_sat}, {8'h7F, 1'b1});
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("bp_after_pop_s_ready", s_ready, 1);
        chk("bp_head_second", {m_res, m_sat}, {8'h81, 1'b1});
        t1 = cyc_n;
        send(16'h0000, 16'h0000, 8'h00, t0);
        chk("bp_third_immediate", t0 - t1, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !m_valid) break;
            cyc();
        end
        chk("bp_drained", 32'(sb.size()), 0);

        // Reset in the middle of a divide; a late div_rdy must be ignored
        send(16'h4000, 16'h1000, 8'h20, t0);
        chk("rmid_req", div_req, 1);
        for (int i = 0; i < 3; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rmid_req_drop", div_req, 0);
        chk("rmid_m_valid", m_valid, 0);
        for (int i = 0; i < 4; i++) cyc();
        force_rdy = 1'b1;
        cyc();
        force_rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("rmid_late_rdy_m_valid", m_valid, 0);
        chk("rmid_late_rdy_req", div_req, 0);
        chk("rmid_s_ready", s_ready, 1);

        chk("sb_empty_end", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
